// File: rtl/robot_ctrl.sv
// Motion controller: classifies a range sample into a zone, debounces it, and runs
// the drive FSM that issues speed/direction/turn commands to the motor stage.
module robot_ctrl #(
  parameter logic [15:0] FAR_TH      = 16'd1000,
  parameter logic [15:0] NEAR_TH     = 16'd300,
  parameter logic [15:0] STOP_TH     = 16'd100,
  parameter int          DEB         = 2,
  parameter int          STOP_CYCLES = 4,
  parameter int          TURN_CYCLES = 8,
  parameter logic [7:0]  SPD_FAST    = 8'd200,
  parameter logic [7:0]  SPD_SLOW    = 8'd80
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [15:0] dist_v,
  output logic [7:0]  speed,
  output logic        dir,
  output logic        turn,
  output logic [2:0]  state,
  output logic        obstacle
);

  typedef enum logic [1:0] {
    Z_CLOSE = 2'd0,
    Z_NEAR  = 2'd1,
    Z_MID   = 2'd2,
    Z_FAR   = 2'd3
  } zone_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CRUISE  = 3'd1,
    S_SLOW    = 3'd2,
    S_STOP    = 3'd3,
    S_REVERSE = 3'd4,
    S_TURN    = 3'd5
  } state_e;

  localparam int             DW        = $clog2(DEB + 1);
  localparam logic [DW-1:0]  DEB_L     = DW'(DEB);
  localparam int             TMAX      = (STOP_CYCLES > TURN_CYCLES) ? STOP_CYCLES : TURN_CYCLES;
  localparam int             TW        = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0]  STOP_LOAD = TW'(STOP_CYCLES - 1);
  localparam logic [TW-1:0]  TURN_LOAD = TW'(TURN_CYCLES - 1);

  zone_e         raw_zone;
  zone_e         fzone, fzone_nxt;
  zone_e         cand, cand_nxt;
  logic [DW-1:0] deb_cnt, deb_cnt_nxt, deb_run;

  state_e        state_q, state_nxt;
  logic [TW-1:0] timer_q, timer_nxt;

  // Threshold-equal values land in the upper zone.
  always_comb begin
    if (dist_v >= FAR_TH)       raw_zone = Z_FAR;
    else if (dist_v >= NEAR_TH) raw_zone = Z_MID;
    else if (dist_v >= STOP_TH) raw_zone = Z_NEAR;
    else                        raw_zone = Z_CLOSE;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    fzone_nxt   = fzone;
    cand_nxt    = cand;
    deb_cnt_nxt = deb_cnt;
    deb_run     = DW'(1);
    if (raw_zone == fzone) begin
      deb_cnt_nxt = '0;
    end else begin
      if ((raw_zone == cand) && (deb_cnt != '0)) deb_run = deb_cnt + DW'(1);
      cand_nxt = raw_zone;
      if (deb_run >= DEB_L) begin
        fzone_nxt   = raw_zone;
        deb_cnt_nxt = '0;
      end else begin
        deb_cnt_nxt = deb_run;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so all flops sample the
  // pre-edge values together, independent of statement order.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      fzone   <= Z_CLOSE;
      cand    <= Z_CLOSE;
      deb_cnt <= '0;
    end else begin
      fzone   <= fzone_nxt;
      cand    <= cand_nxt;
      deb_cnt <= deb_cnt_nxt;
    end
  end

  // Dwell timer is loaded with N-1 on entry, so the state lasts exactly N cycles.
  always_comb begin
    state_nxt = state_q;
    timer_nxt = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (fzone == Z_FAR)      state_nxt = S_CRUISE;
        else if (fzone == Z_MID) state_nxt = S_SLOW;
      end
      S_CRUISE: begin
        if (fzone == Z_MID) begin
          state_nxt = S_SLOW;
        end else if (fzone != Z_FAR) begin
          state_nxt = S_STOP;
          timer_nxt = STOP_LOAD;
        end
      end
      S_SLOW: begin
        if (fzone == Z_FAR) begin
          state_nxt = S_CRUISE;
        end else if (fzone != Z_MID) begin
          state_nxt = S_STOP;
          timer_nxt = STOP_LOAD;
        end
      end
      S_STOP: begin
        if (timer_q != '0) begin
          timer_nxt = timer_q - TW'(1);
        end else if (fzone == Z_CLOSE) begin
          state_nxt = S_REVERSE;
        end else begin
          state_nxt = S_TURN;
          timer_nxt = TURN_LOAD;
        end
      end
      S_REVERSE: begin
        if (fzone != Z_CLOSE) begin
          state_nxt = S_TURN;
          timer_nxt = TURN_LOAD;
        end
      end
      S_TURN: begin
        if (timer_q != '0) begin
          timer_nxt = timer_q - TW'(1);
        end else begin
          unique case (fzone)
            Z_FAR:   state_nxt = S_CRUISE;
            Z_MID:   state_nxt = S_SLOW;
            Z_NEAR:  timer_nxt = TURN_LOAD;
            default: state_nxt = S_REVERSE;
          endcase
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_nxt;
      timer_q <= timer_nxt;
    end
  end

  // Moore outputs: decoded only from registered state and filtered zone.
  always_comb begin
    speed = 8'd0;
    dir   = 1'b0;
    turn  = 1'b0;
    unique case (state_q)
      S_CRUISE:  speed = SPD_FAST;
      S_SLOW:    speed = SPD_SLOW;
      S_REVERSE: begin
        speed = SPD_SLOW;
        dir   = 1'b1;
      end
      S_TURN: begin
        speed = SPD_SLOW;
        turn  = 1'b1;
      end
      default: speed = 8'd0;
    endcase
  end

  assign state    = state_q;
  assign obstacle = (fzone == Z_NEAR) || (fzone == Z_CLOSE);

endmodule

// File: tb/tb_robot_ctrl.sv
// Randomized bench for robot_ctrl: a zone/history-based reference model predicts
// every output each cycle; directed segments pin down the key scenarios.
module tb_robot_ctrl;

  localparam int DEB   = 2;
  localparam int STOPC = 4;
  localparam int TURNC = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] dist_v;
  logic [7:0]  speed;
  logic        dir;
  logic        turn;
  logic [2:0]  state;
  logic        obstacle;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: zones 0..3 = CLOSE..FAR, states 0..5 as in the port encoding.
  int m_state;
  int m_fz;
  int m_left;
  int hist[$];

  robot_ctrl u_dut (
    .clk      (clk),
    .rstn     (rstn),
    .dist_v   (dist_v),
    .speed    (speed),
    .dir      (dir),
    .turn     (turn),
    .state    (state),
    .obstacle (obstacle)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int zone_of(input int d);
    if (d >= 1000) return 3;
    if (d >= 300)  return 2;
    if (d >= 100)  return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_fz    = 0;
    m_left  = 0;
    hist.delete();
  endtask

  // One rising edge: the FSM sees the filtered zone from before the edge, then the
  // filtered zone adopts the raw zone once the last DEB samples agree on a new zone.
  task automatic model_edge(input int d);
    int  ns;
    bit  same;
    ns = m_state;
    case (m_state)
      0: if (m_fz == 3) ns = 1; else if (m_fz == 2) ns = 2;
      1: if (m_fz == 2) ns = 2; else if (m_fz < 2) begin ns = 3; m_left = STOPC; end
      2: if (m_fz == 3) ns = 1; else if (m_fz < 2) begin ns = 3; m_left = STOPC; end
      3: begin
        if (m_left > 1) m_left--;
        else if (m_fz == 0) ns = 4;
        else begin ns = 5; m_left = TURNC; end
      end
      4: if (m_fz != 0) begin ns = 5; m_left = TURNC; end
      5: begin
        if (m_left > 1) m_left--;
        else if (m_fz == 3) ns = 1;
        else if (m_fz == 2) ns = 2;
        else if (m_fz == 1) m_left = TURNC;
        else ns = 4;
      end
      default: ns = 0;
    endcase
    hist.push_back(zone_of(d));
    if (hist.size() > DEB) void'(hist.pop_front());
    if (hist.size() == DEB) begin
      same = 1'b1;
      foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
      if (same && hist[0] != m_fz) m_fz = hist[0];
    end
    m_state = ns;
  endtask

  task automatic compare_all();
    int exp_speed;
    exp_speed = (m_state == 1) ? 200 : (m_state == 2 || m_state == 4 || m_state == 5) ? 80 : 0;
    check("state", state, m_state);
    check("speed", speed, exp_speed);
    check("dir", dir, (m_state == 4) ? 1 : 0);
    check("turn", turn, (m_state == 5) ? 1 : 0);
    check("obstacle", obstacle, (m_fz < 2) ? 1 : 0);
  endtask

  task automatic cycle(input logic [15:0] d);
    dist_v = d;
    @(posedge clk);
    model_edge(int'(d));
    #1;
    compare_all();
  endtask

  // Asserts reset between edges and checks the outputs before any clock edge arrives.
  task automatic do_reset(input int n);
    #2;
    rstn = 1'b1;
    model_reset();
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_speed", speed, 0);
    check("async_rst_dir", dir, 0);
    check("async_rst_turn", turn, 0);
    check("async_rst_obst", obstacle, 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rstn = 1'b0;
  endtask

  function automatic logic [15:0] rand_dist();
    int z;
    z = $urandom_range(0, 4);
    case (z)
      0: return 16'($urandom_range(0, 99));
      1: return 16'($urandom_range(100, 299));
      2: return 16'($urandom_range(300, 999));
      3: return 16'($urandom_range(1000, 65535));
      default: begin
        case ($urandom_range(0, 3))
          0: return 16'd100;
          1: return 16'd300;
          2: return 16'd999;
          default: return 16'd1000;
        endcase
      end
    endcase
  endfunction

  initial begin
    model_reset();
    rstn   = 1'b1;
    dist_v = 16'd0;
    #1;
    compare_all();
    repeat (3) begin
      @(posedge clk);
      #1;
      compare_all();
    end
    rstn = 1'b0;

    repeat (5) cycle(16'd0);
    check("idle_hold_state", state, 0);
    check("idle_hold_obst", obstacle, 1);

    repeat (3) cycle(16'd2000);
    check("cruise_state", state, 1);
    check("cruise_speed", speed, 200);
    check("cruise_obst", obstacle, 0);

    repeat (3) cycle(16'd500);
    check("slow_state", state, 2);
    check("slow_speed", speed, 80);

    repeat (3) cycle(16'd1000);
    check("far_thresh_state", state, 1);

    repeat (3) cycle(16'd150);
    check("stop_state", state, 3);
    check("stop_speed", speed, 0);
    check("stop_obst", obstacle, 1);
    repeat (3) cycle(16'd150);
    check("stop_dwell", state, 3);
    cycle(16'd150);
    check("turn_state", state, 5);
    check("turn_flag", turn, 1);
    check("turn_speed", speed, 80);

    repeat (7) cycle(16'd2000);
    check("turn_dwell", state, 5);
    cycle(16'd2000);
    check("turn_to_cruise", state, 1);

    repeat (3) cycle(16'd50);
    check("close_stop", state, 3);
    repeat (4) cycle(16'd50);
    check("reverse_state", state, 4);
    check("reverse_dir", dir, 1);
    check("reverse_speed", speed, 80);

    repeat (3) cycle(16'd120);
    check("rev_to_turn", state, 5);
    repeat (10) cycle(16'd2000);
    check("back_cruise", state, 1);

    cycle(16'd50);
    repeat (4) cycle(16'd2000);
    check("glitch_state", state, 1);
    check("glitch_obst", obstacle, 0);

    repeat (7) cycle(16'd150);
    repeat (2) cycle(16'd150);
    check("pre_reset_turn", state, 5);
    do_reset(3);

    for (int seg = 0; seg < 500; seg++) begin
      logic [15:0] d;
      int          len;
      if ($urandom_range(0, 49) == 0) begin
        do_reset($urandom_range(1, 3));
      end
      d   = rand_dist();
      len = ($urandom_range(0, 5) == 0) ? 1 : $urandom_range(2, 14);
      repeat (len) cycle(d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/robot_ctrl.md
Name: robot_ctrl

Overview:
- Autonomous-robot motion controller driven by a 16-bit distance sensor value.
- Classifies distance into zones, debounces the zone, and runs a drive FSM (idle/cruise/slow/stop/reverse/turn).
- The FSM produces motor speed, direction and turn commands for the motor-driver block.
- Sits between the range-sensor interface and the motor PWM stage.

Parameters:
- FAR_TH, 16'd1000, dist_v >= FAR_TH is zone FAR
- NEAR_TH, 16'd300, NEAR_TH <= dist_v < FAR_TH is zone MID
- STOP_TH, 16'd100, STOP_TH <= dist_v < NEAR_TH is zone NEAR; below STOP_TH is zone CLOSE
- DEB, 2, consecutive samples of a new zone required before the filtered zone changes (>=1)
- STOP_CYCLES, 4, cycles spent in STOP
- TURN_CYCLES, 8, cycles spent in TURN per attempt
- SPD_FAST, 8'd200, CRUISE speed
- SPD_SLOW, 8'd80, SLOW/REVERSE/TURN speed

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rstn  in  1  asynchronous, active-high reset (1 = reset asserted)
- dist_v  in  16  unsigned distance sample, sampled every clock
- speed  out  8  motor speed command
- dir  out  1  0 = forward, 1 = reverse
- turn  out  1  1 = rotate in place
- state  out  3  IDLE=0, CRUISE=1, SLOW=2, STOP=3, REVERSE=4, TURN=5
- obstacle  out  1  1 when the filtered zone is NEAR or CLOSE

Behaviour:
- Reset (rstn=1, asynchronous) takes effect immediately regardless of clk:
  - state=IDLE, fzone=CLOSE, debounce candidate=CLOSE, counters=0.
  - Outputs: speed=0, dir=0, turn=0, obstacle=1.
- Raw zone: combinational from dist_v using the thresholds above. A value equal to a threshold falls in the upper zone. Comparisons are unsigned.
- Debounce:
  - If raw==fzone: clear the debounce count.
  - Otherwise, count consecutive edges with the same raw value; a different raw value restarts the count at 1.
  - fzone<=raw on the DEB-th consecutive matching edge.
  - Latency: dist_v applied before edge k updates fzone at edge k+DEB-1.
- FSM: registered state; it reacts to fzone one edge after fzone changes. Outputs are decoded from the state register (Moore, no combinational path from dist_v).
- IDLE: speed 0. fzone FAR -> CRUISE; MID -> SLOW; otherwise stay.
- CRUISE: speed SPD_FAST, dir 0. MID -> SLOW; NEAR/CLOSE -> STOP.
- SLOW: speed SPD_SLOW, dir 0. FAR -> CRUISE; NEAR/CLOSE -> STOP.
- STOP: speed 0. Dwell exactly STOP_CYCLES cycles, counter loaded on entry. Then CLOSE -> REVERSE, else -> TURN.
- REVERSE: speed SPD_SLOW, dir 1. Stays while fzone==CLOSE; any other zone -> TURN.
- TURN: speed SPD_SLOW, turn 1, dir 0.
  - Dwell exactly TURN_CYCLES cycles.
  - Then FAR -> CRUISE, MID -> SLOW, NEAR -> TURN again with the counter reloaded, CLOSE -> REVERSE.
- Zone changes during the STOP/TURN dwell do not shorten the dwell; they are only evaluated at dwell end.
- Unused state encodings (6, 7) -> IDLE on the next edge.
- Reset mid-operation: immediate return to reset values; the debounce restarts from CLOSE.
- speed is 0 in IDLE and STOP only. dir=1 only in REVERSE. turn=1 only in TURN.

Test Plan:
- Reset then hold dist_v=0 with rstn=0 -> state stays IDLE, speed=0, dir=0, turn=0, obstacle=1 indefinitely.
- Release reset with dist_v=2000 -> fzone FAR after 2 edges; state=CRUISE on edge 3; speed=200, obstacle=0.
- From CRUISE, dist_v=500 -> SLOW (speed=80) 3 edges later. Then dist_v=1000 (exact threshold) -> CRUISE, speed=200.
- From CRUISE, dist_v=150 -> STOP with speed=0 and obstacle=1 for 4 cycles.
  - Then TURN with turn=1 and speed=80 for 8 cycles.
  - With dist_v=2000 during the turn -> CRUISE.
- From CRUISE, dist_v=50 -> STOP 4 cycles -> REVERSE (dir=1, speed=80). Then dist_v=120 -> after debounce, TURN.
- Single-cycle glitch dist_v=50 during CRUISE -> no zone or state change.
- rstn pulsed mid-TURN -> outputs return to IDLE values without waiting for a clk edge.
